// File: rtl/bcd_pkg.sv
// Shared definitions for the serial shift-and-add-3 binary-to-BCD converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    localparam logic [3:0] DabbleThreshold = 4'd5;
    localparam logic [3:0] DabbleOffset    = 4'd3;

    // True when DIGITS decimal digits can hold every WIDTH-bit value (10^digits > 2^width).
    function automatic bit digits_ok(input int unsigned width, input int unsigned digits);
        longint unsigned p10;
        p10 = 64'd1;
        if (width >= 63) begin
            return 1'b0;
        end
        for (int unsigned i = 0; i < digits; i++) begin
            if (p10 > 64'd1844674407370955161) begin
                return 1'b1;
            end
            p10 = p10 * 64'd10;
        end
        return p10 > (64'd1 << width);
    endfunction

endpackage

// File: rtl/bcd_serial_converter_if.sv
// Request/result bundle between a binary source and the BCD converter.
interface bcd_serial_converter_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
);

    logic                  start;
    logic [WIDTH-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;

    modport master (
        output start,
        output bin,
        input  busy,
        input  done,
        input  bcd
    );

    modport slave (
        input  start,
        input  bin,
        output busy,
        output done,
        output bcd
    );

endinterface

// File: rtl/dabble_digit.sv
// One BCD correction cell: a digit of 5 or more gets +3 ahead of the next left shift.
module dabble_digit
    import bcd_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    always_comb begin
        digit_o = digit_i;
        if (digit_i >= DabbleThreshold) begin
            digit_o = digit_i + DabbleOffset;
        end
    end

endmodule

// File: rtl/bcd_serial_converter.sv
// Sequential double-dabble converter: one WIDTH-bit value per request, result held for display.
module bcd_serial_converter
    import bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input logic                    CLOCK_50,
    input logic                    reset,
    bcd_serial_converter_if.slave  bus
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned BcdW = 4 * DIGITS;

    if (!digits_ok(WIDTH, DIGITS)) begin : gen_digits_check
        $error("bcd_serial_converter: DIGITS too small for WIDTH");
    end

    state_e            state_q;
    logic [WIDTH-1:0]  bin_q;
    logic [BcdW-1:0]   digits_q;
    logic [BcdW-1:0]   digits_adj;
    logic [CntW-1:0]   cnt_q;
    logic              busy_q;
    logic              done_q;
    logic [BcdW-1:0]   bcd_q;

    for (genvar i = 0; i < DIGITS; i++) begin : gen_digit
        dabble_digit u_dabble (
            .digit_i (digits_q[4*i +: 4]),
            .digit_o (digits_adj[4*i +: 4])
        );
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q  <= StIdle;
            bin_q    <= '0;
            digits_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            bcd_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        bin_q    <= bus.bin;
                        digits_q <= '0;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= StShift;
                    end
                end
                StShift: begin
                    // {digits, binary} shifts as one vector after correction.
                    digits_q <= {digits_adj[BcdW-2:0], bin_q[WIDTH-1]};
                    bin_q    <= bin_q << 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    bcd_q   <= digits_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.bcd  = bcd_q;

endmodule

// File: tb/tb_bcd_serial_converter.sv
// Directed, scoreboarded bench for bcd_serial_converter with a decimal reference model.
module tb_bcd_serial_converter;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    logic [11:0] exp_q[$];

    bcd_serial_converter_if #(.WIDTH(8), .DIGITS(3)) bus ();

    bcd_serial_converter #(
        .WIDTH  (8),
        .DIGITS (3)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (reset),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] ref_bcd(input int v);
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] o;
        h = 4'((v / 100) % 10);
        t = 4'((v / 10) % 10);
        o = 4'(v % 10);
        return {h, t, o};
    endfunction

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for done after an accepted start; checks latency, busy, hold and result.
    task automatic wait_done(input string tag, input logic [11:0] held);
        int k;
        k = 0;
        do begin
            cycle();
            k++;
            if (!bus.done) begin
                check({tag, "_busy"}, 32'(bus.busy), 32'd1);
                check({tag, "_hold"}, 32'(bus.bcd), 32'(held));
            end
        end while (!bus.done && k < 20);
        check({tag, "_latency"}, 32'(k), 32'd9);
        check({tag, "_busy_drop"}, 32'(bus.busy), 32'd0);
        check({tag, "_sb_size"}, 32'(exp_q.size()), 32'd1);
        if (exp_q.size() != 0) begin
            check({tag, "_bcd"}, 32'(bus.bcd), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic convert(input string tag, input int v);
        logic [11:0] held;
        held      = bus.bcd;
        bus.bin   = 8'(v);
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        exp_q.push_back(ref_bcd(v));
        check({tag, "_accept"}, 32'(bus.busy), 32'd1);
        wait_done(tag, held);
        cycle();
        check({tag, "_done_fall"}, 32'(bus.done), 32'd0);
        check({tag, "_bcd_hold"}, 32'(bus.bcd), 32'(ref_bcd(v)));
    endtask

    initial begin
        int dones;
        logic [11:0] held;
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.bin   = '0;
        cycle();
        cycle();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_bcd", 32'(bus.bcd), 32'd0);
        reset = 1'b0;
        cycle();
        check("idle_busy", 32'(bus.busy), 32'd0);

        convert("c255", 255);
        convert("c0", 0);
        convert("c99", 99);
        convert("c100", 100);

        // Restart and new bin mid-conversion must be ignored.
        held      = bus.bcd;
        bus.bin   = 8'd128;
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        exp_q.push_back(ref_bcd(128));
        dones = 0;
        for (int i = 1; i <= 12; i++) begin
            if (i == 4) begin
                bus.start = 1'b1;
                bus.bin   = 8'd7;
            end else begin
                bus.start = 1'b0;
            end
            cycle();
            if (bus.done) begin
                dones++;
                check("c128_latency", 32'(i), 32'd9);
                check("c128_bcd", 32'(bus.bcd), 32'(exp_q.pop_front()));
            end else if (i < 9) begin
                check("c128_hold", 32'(bus.bcd), 32'(held));
            end
            if (i > 9) begin
                check("c128_no_restart", 32'(bus.busy), 32'd0);
            end
        end
        check("c128_done_count", 32'(dones), 32'd1);
        check("c128_sb_empty", 32'(exp_q.size()), 32'd0);

        // Reset at cycle 5 aborts the conversion.
        bus.bin   = 8'd200;
        bus.start = 1'b1;
        cycle();
        bus.start = 1'b0;
        exp_q.push_back(ref_bcd(200));
        for (int i = 1; i <= 4; i++) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        void'(exp_q.pop_front());
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_bcd", 32'(bus.bcd), 32'd0);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (bus.done) dones++;
        end
        check("abort_no_done", 32'(dones), 32'd0);
        convert("c200", 200);

        // Reset and start together: reset wins.
        bus.bin   = 8'd55;
        bus.start = 1'b1;
        reset     = 1'b1;
        cycle();
        reset     = 1'b0;
        bus.start = 1'b0;
        check("rst_start_busy", 32'(bus.busy), 32'd0);
        cycle();
        check("rst_start_idle", 32'(bus.busy), 32'd0);

        // start held high: back-to-back conversions over the full range.
        bus.start = 1'b1;
        for (int v = 0; v < 256; v++) begin
            held    = bus.bcd;
            bus.bin = 8'(v);
            cycle();
            exp_q.push_back(ref_bcd(v));
            check("b2b_accept", 32'(bus.busy), 32'd1);
            wait_done("b2b", held);
        end
        bus.start = 1'b0;
        cycle();
        check("b2b_final_done", 32'(bus.done), 32'd0);
        check("b2b_final_bcd", 32'(bus.bcd), 32'(ref_bcd(255)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
